util_irq2axis: RTL and testbench

Interrupt collector that sits directly upstream of the AXI-Stream-to-MSI stage. It edge-detects up to 32 same-clock interrupt lines and latches each event as a per-source pending bit. Pending sources are picked in round-robin order, and each one is emitted as a single 8-bit AXI-Stream beat carrying its interrupt number. That number is consumed downstream as the MSI vector.

---
 rtl/util_irq2axis.sv | 87 ++++++++
 tb/tb_util_irq2axis.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/util_irq2axis.sv
// Interrupt collector: edge-detects irq lines into pending bits and emits one
// 8-bit AXI-Stream beat per event, picking pending sources in round-robin order.
module util_irq2axis #(
    parameter int unsigned NUM_IRQ  = 8,
    parameter int unsigned BASE_NUM = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic [NUM_IRQ-1:0] pending,
    output logic [7:0]         m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready
);

    localparam int unsigned   IW       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_IRQ - 1);

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] clr;
    logic [7:0]         tdata_q;
    logic               tvalid_q;
    logic [IW-1:0]      last_q;
    logic [IW-1:0]      sel;
    logic [IW-1:0]      idx;
    logic               found;
    logic               load_ok;

    assign rise    = irq & ~irq_q;
    assign cand    = pending_q & ~irq_mask;
    assign load_ok = ~tvalid_q | m_axis_tready;

    // Scan last+1, last+2, ... wrapping; k = NUM_IRQ revisits last itself.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_IRQ; k++) begin
            idx = IW'((32'(last_q) + k) % NUM_IRQ);
            if (!found && cand[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        clr = '0;
        if (load_ok && found) begin
            clr[sel] = 1'b1;
        end
        // Set wins over clear so an edge landing on the load cycle is kept.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q     <= '0;
            pending_q <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            last_q    <= LAST_RST;
        end else begin
            irq_q     <= irq;
            pending_q <= pending_d;
            if (load_ok) begin
                if (found) begin
                    tdata_q  <= 8'(BASE_NUM) + 8'(sel);
                    tvalid_q <= 1'b1;
                    last_q   <= sel;
                end else begin
                    tvalid_q <= 1'b0;
                end
            end
        end
    end

    assign pending       = pending_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_util_irq2axis.sv
// Directed self-checking bench for util_irq2axis (NUM_IRQ=8; BASE_NUM 0 and 4).
module tb_util_irq2axis;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq;
    logic [7:0] irq_mask;
    logic [7:0] pending;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    logic [7:0] irq_b;
    logic [7:0] mask_b;
    logic [7:0] pending_b;
    logic [7:0] tdata_b;
    logic       tvalid_b;
    logic       tready_b;

    int checks;
    int failures;

    util_irq2axis #(.NUM_IRQ(8), .BASE_NUM(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq           (irq),
        .irq_mask      (irq_mask),
        .pending       (pending),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready)
    );

    util_irq2axis #(.NUM_IRQ(8), .BASE_NUM(4)) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq           (irq_b),
        .irq_mask      (mask_b),
        .pending       (pending_b),
        .m_axis_tdata  (tdata_b),
        .m_axis_tvalid (tvalid_b),
        .m_axis_tready (tready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        irq      = 8'h05;
        irq_mask = 8'h00;
        tready   = 1'b1;
        irq_b    = 8'h00;
        mask_b   = 8'h00;
        tready_b = 1'b1;

        // Reset and lines already high at release
        tick();
        tick();
        chk("rst_tvalid", 32'(tvalid), 0);
        chk("rst_tdata", 32'(tdata), 0);
        chk("rst_pending", 32'(pending), 0);
        rst_n = 1'b1;
        tick();
        chk("rel_pending", 32'(pending), 32'h05);
        chk("rel_tvalid", 32'(tvalid), 0);
        tick();
        chk("rel_beat0_tdata", 32'(tdata), 32'h00);
        chk("rel_beat0_tvalid", 32'(tvalid), 1);
        chk("rel_beat0_pending", 32'(pending), 32'h04);
        tick();
        chk("rel_beat1_tdata", 32'(tdata), 32'h02);
        chk("rel_beat1_pending", 32'(pending), 32'h00);
        tick();
        chk("rel_idle_tvalid", 32'(tvalid), 0);
        chk("rel_idle_tdata_hold", 32'(tdata), 32'h02);
        irq = 8'h00;

        // Latency with BASE_NUM = 4
        irq_b = 8'h08;
        tick();
        chk("lat_pending", 32'(pending_b), 32'h08);
        chk("lat_tvalid_early", 32'(tvalid_b), 0);
        irq_b = 8'h00;
        tick();
        chk("lat_tdata", 32'(tdata_b), 32'h07);
        chk("lat_tvalid", 32'(tvalid_b), 1);
        chk("lat_pending_clr", 32'(pending_b), 0);
        tick();
        chk("lat_tvalid_1cyc", 32'(tvalid_b), 0);

        // Round-robin with backpressure, starting from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        irq    = 8'h62;
        tready = 1'b0;
        tick();
        chk("rr_pending", 32'(pending), 32'h62);
        chk("rr_tvalid_early", 32'(tvalid), 0);
        tick();
        chk("rr_first_tdata", 32'(tdata), 32'h01);
        chk("rr_first_pending", 32'(pending), 32'h60);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr_hold1_tdata", 32'(tdata), 32'h01);
            chk("rr_hold1_tvalid", 32'(tvalid), 1);
        end
        tready = 1'b1;
        tick();
        chk("rr_second_tdata", 32'(tdata), 32'h05);
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr_hold5_tdata", 32'(tdata), 32'h05);
            chk("rr_hold5_tvalid", 32'(tvalid), 1);
        end
        tready = 1'b1;
        tick();
        chk("rr_third_tdata", 32'(tdata), 32'h06);
        chk("rr_third_pending", 32'(pending), 0);
        tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rr_hold6_tdata", 32'(tdata), 32'h06);
        end
        tready = 1'b1;
        tick();
        chk("rr_drain_tvalid", 32'(tvalid), 0);
        irq = 8'h00;
        tick();
        irq = 8'h41;
        tick();
        chk("rr_wrap_pending", 32'(pending), 32'h41);
        tick();
        chk("rr_wrap_first", 32'(tdata), 32'h00);
        tick();
        chk("rr_wrap_second", 32'(tdata), 32'h06);
        tick();
        chk("rr_wrap_idle", 32'(tvalid), 0);

        // Coalescing: output register occupied by source 7
        irq = 8'h00;
        tick();
        tready = 1'b0;
        irq    = 8'h80;
        tick();
        irq = 8'h00;
        tick();
        chk("coal_pre_tdata", 32'(tdata), 32'h07);
        for (int i = 0; i < 3; i++) begin
            irq = 8'h04;
            tick();
            irq = 8'h00;
            tick();
        end
        chk("coal_pending", 32'(pending), 32'h04);
        chk("coal_hold_tdata", 32'(tdata), 32'h07);
        tready = 1'b1;
        tick();
        chk("coal_beat_tdata", 32'(tdata), 32'h02);
        chk("coal_beat_pending", 32'(pending), 0);
        tick();
        chk("coal_single_beat", 32'(tvalid), 0);

        // Set wins: edge on irq[2] on the cycle its beat loads
        tready = 1'b0;
        irq    = 8'h80;
        tick();
        irq = 8'h00;
        tick();
        irq = 8'h04;
        tick();
        irq = 8'h00;
        tick();
        tready = 1'b1;
        irq    = 8'h04;
        tick();
        chk("setwin_tdata", 32'(tdata), 32'h02);
        chk("setwin_pending", 32'(pending), 32'h04);
        irq = 8'h00;
        tick();
        chk("setwin_second_tdata", 32'(tdata), 32'h02);
        chk("setwin_second_tvalid", 32'(tvalid), 1);
        chk("setwin_second_pending", 32'(pending), 0);
        tick();
        chk("setwin_idle", 32'(tvalid), 0);

        // Masking
        irq_mask = 8'h10;
        irq      = 8'h10;
        tick();
        chk("mask_pending", 32'(pending), 32'h10);
        irq = 8'h00;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("mask_no_beat", 32'(tvalid), 0);
        end
        chk("mask_pending_kept", 32'(pending), 32'h10);
        irq_mask = 8'h00;
        tick();
        chk("unmask_tdata", 32'(tdata), 32'h04);
        chk("unmask_tvalid", 32'(tvalid), 1);
        chk("unmask_pending", 32'(pending), 0);
        tick();
        chk("unmask_idle", 32'(tvalid), 0);

        // Asynchronous reset mid-operation
        tready = 1'b0;
        irq    = 8'h10;
        tick();
        irq = 8'h0F;
        tick();
        chk("mid_pre_tdata", 32'(tdata), 32'h04);
        chk("mid_pre_pending", 32'(pending), 32'h0F);
        irq = 8'h00;
        tick();
        chk("mid_pre_tvalid", 32'(tvalid), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 32'(tvalid), 0);
        chk("mid_rst_tdata", 32'(tdata), 0);
        chk("mid_rst_pending", 32'(pending), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mid_post_no_beat", 32'(tvalid), 0);
        end
        chk("mid_post_pending", 32'(pending), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
